// File: rtl/sap_demux_pkg.sv
// Shared types and constants for the registered bus demultiplexer.
package sap_demux_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int unsigned DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // Increment that sticks at the maximum value instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == DROP_CNT_MAX) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: a single-entry holding register with a valid/ready handshake.
module demux_slot
  import sap_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  input  logic             ready,
  output logic             free
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Slot state and held word; data survives consumption so the output never floats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Next state: a load always wins; a FULL slot only drains when not refilled.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (load) begin
          state_d = SLOT_FULL;
          data_d  = d;
        end
      end
      SLOT_FULL: begin
        if (load) begin
          data_d = d;
        end else if (ready) begin
          state_d = SLOT_EMPTY;
        end
      end
    endcase
  end

  assign q     = data_q;
  assign valid = (state_q == SLOT_FULL);
  // Ready passes straight through so a draining slot can refill in the same cycle.
  assign free  = (state_q == SLOT_EMPTY) || ready;

endmodule

// File: rtl/bus_demux_reg.sv
// Registered 1-to-N bus demultiplexer with per-channel back-pressure and broadcast.
module bus_demux_reg
  import sap_demux_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [DROP_CNT_W-1:0]     drop_cnt,
  input  logic                      drop_clr
);

  logic [CHANNELS-1:0]   sel_hit;
  logic [CHANNELS-1:0]   slot_free;
  logic [CHANNELS-1:0]   slot_load;
  logic                  sel_illegal;
  logic                  accept;
  logic                  drop_inc;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // One-hot decode of the unicast select.
  always_comb begin
    sel_hit = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      sel_hit[k] = (32'(in_sel) == k);
    end
  end

  assign sel_illegal = !in_bcast && (32'(in_sel) >= CHANNELS);

  // Broadcast needs every slot free; an illegal select is always taken and discarded.
  always_comb begin
    in_ready = 1'b0;
    if (in_bcast) begin
      in_ready = &slot_free;
    end else if (sel_illegal) begin
      in_ready = 1'b1;
    end else begin
      in_ready = |(sel_hit & slot_free);
    end
  end

  assign accept    = in_valid && in_ready;
  assign drop_inc  = accept && sel_illegal;
  assign slot_load = !accept ? '0 : (in_bcast ? '1 : sel_hit);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (slot_load[k]),
      .d     (in_data),
      .q     (out_data[k*WIDTH +: WIDTH]),
      .valid (out_valid[k]),
      .ready (out_ready[k]),
      .free  (slot_free[k])
    );
  end

  // Drop counter next value: clear beats increment, increment saturates.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_clr) begin
      drop_cnt_d = '0;
    end else if (drop_inc) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_demux_reg.sv
// Self-checking bench: 16-channel instance against a slot/queue model, 12-channel instance for drops.
module tb_bus_demux_reg;

  logic         clk;
  logic         rst_n;

  logic [7:0]   in_data;
  logic [3:0]   in_sel;
  logic         in_bcast, in_valid, in_ready;
  logic [127:0] out_data;
  logic [15:0]  out_valid, out_ready;
  logic [7:0]   drop_cnt;
  logic         drop_clr;

  logic [7:0]   b_in_data;
  logic [3:0]   b_in_sel;
  logic         b_in_bcast, b_in_valid, b_in_ready;
  logic [95:0]  b_out_data;
  logic [11:0]  b_out_valid, b_out_ready;
  logic [7:0]   b_drop_cnt;
  logic         b_drop_clr;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: one-entry slot per channel plus a per-channel queue of words owed to the consumer.
  bit   [15:0] mv;
  logic [7:0]  md[16];
  logic [7:0]  sb[16][$];
  bit          last_rdy;

  typedef struct {
    logic [3:0]  sel;
    logic        valid;
    logic        clr;
    logic [11:0] ordy;
    logic        exp_rdy;
    logic [7:0]  exp_cnt;
    logic [11:0] exp_ov;
  } vec_t;
  vec_t vecs[10];

  bus_demux_reg #(.WIDTH(8), .CHANNELS(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
  );

  bus_demux_reg #(.WIDTH(8), .CHANNELS(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_in_sel), .in_bcast(b_in_bcast),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .drop_cnt(b_drop_cnt), .drop_clr(b_drop_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    bit all_free = 1'b1;
    for (int k = 0; k < 16; k++) if (mv[k] && !out_ready[k]) all_free = 1'b0;
    if (in_bcast) return all_free;
    return !mv[in_sel] || out_ready[in_sel];
  endfunction

  function automatic logic [127:0] model_data();
    logic [127:0] r = '0;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = md[k];
    return r;
  endfunction

  // One clock of the 16-channel instance; entered #1 after a rising edge with inputs applied.
  task automatic cyc();
    bit   [15:0] mv_n;
    logic [7:0]  md_n[16];
    logic [7:0]  w;
    #1;
    last_rdy = model_ready();
    check("in_ready", 128'(in_ready), 128'(last_rdy));
    mv_n = mv;
    md_n = md;
    for (int k = 0; k < 16; k++) begin
      if (mv[k] && out_ready[k]) begin
        mv_n[k] = 1'b0;
        if (sb[k].size() == 0) begin
          check("sb_extra_word", 128'(1), 128'(0));
        end else begin
          w = sb[k].pop_front();
          check("sb_order", 128'(out_data[k*8 +: 8]), 128'(w));
        end
      end
    end
    if (in_valid && last_rdy) begin
      for (int k = 0; k < 16; k++) begin
        if (in_bcast || in_sel == 4'(k)) begin
          mv_n[k] = 1'b1;
          md_n[k] = in_data;
          sb[k].push_back(in_data);
        end
      end
    end
    @(posedge clk);
    mv = mv_n;
    md = md_n;
    #1;
    check("out_valid", 128'(out_valid), 128'(mv));
    check("out_data", out_data, model_data());
  endtask

  task automatic model_reset();
    mv = '0;
    for (int k = 0; k < 16; k++) begin
      md[k] = '0;
      sb[k].delete();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_data = '0; in_sel = '0; in_bcast = 1'b0; in_valid = 1'b0; out_ready = '0; drop_clr = 1'b0;
    b_in_data = 8'h3C; b_in_sel = '0; b_in_bcast = 1'b0; b_in_valid = 1'b0; b_out_ready = '1; b_drop_clr = 1'b0;
    model_reset();
    last_rdy = 1'b1;

    vecs[0] = '{4'd14, 1'b1, 1'b0, 12'hFFF, 1'b1, 8'd1, 12'h000};
    vecs[1] = '{4'd14, 1'b1, 1'b0, 12'hFFF, 1'b1, 8'd2, 12'h000};
    vecs[2] = '{4'd14, 1'b1, 1'b0, 12'hFFF, 1'b1, 8'd3, 12'h000};
    vecs[3] = '{4'd14, 1'b0, 1'b0, 12'hFFF, 1'b1, 8'd3, 12'h000};
    vecs[4] = '{4'd2,  1'b1, 1'b0, 12'h000, 1'b1, 8'd3, 12'h004};
    vecs[5] = '{4'd2,  1'b1, 1'b0, 12'h000, 1'b0, 8'd3, 12'h004};
    vecs[6] = '{4'd13, 1'b1, 1'b0, 12'h000, 1'b1, 8'd4, 12'h004};
    vecs[7] = '{4'd12, 1'b1, 1'b1, 12'hFFF, 1'b1, 8'd0, 12'h000};
    vecs[8] = '{4'd15, 1'b1, 1'b0, 12'hFFF, 1'b1, 8'd1, 12'h000};
    vecs[9] = '{4'd11, 1'b0, 1'b1, 12'hFFF, 1'b1, 8'd0, 12'h000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", out_data, 128'(0));
    check("rst_drop_cnt", 128'(drop_cnt), 128'(0));
    check("rst_b_drop_cnt", 128'(b_drop_cnt), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    #1;
    check("idle_in_ready", 128'(in_ready), 128'(1));

    // Drop counter and illegal selects on the 12-channel instance
    for (int i = 0; i < 10; i++) begin
      b_in_sel = vecs[i].sel;
      b_in_valid = vecs[i].valid;
      b_drop_clr = vecs[i].clr;
      b_out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_in_ready", i), 128'(b_in_ready), 128'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_drop_cnt", i), 128'(b_drop_cnt), 128'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_out_valid", i), 128'(b_out_valid), 128'(vecs[i].exp_ov));
    end
    b_in_sel = 4'd14; b_in_valid = 1'b1; b_drop_clr = 1'b0; b_out_ready = '1;
    repeat (300) @(posedge clk);
    #1;
    check("drop_saturate", 128'(b_drop_cnt), 128'(255));
    check("drop_no_load", 128'(b_out_valid), 128'(0));
    b_drop_clr = 1'b1;
    @(posedge clk);
    #1;
    check("drop_clr_priority", 128'(b_drop_cnt), 128'(0));
    b_in_valid = 1'b0; b_drop_clr = 1'b0;
    check("no_drop_16ch", 128'(drop_cnt), 128'(0));

    // Unicast to channel 5 with its consumer ready
    out_ready = 16'h0020;
    in_sel = 4'd5; in_data = 8'hA5; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("uc5_valid", 128'(out_valid), 128'(16'h0020));
    check("uc5_data", out_data, 128'(8'hA5) << 40);
    cyc();
    check("uc5_pulse", 128'(out_valid), 128'(0));
    check("uc5_hold", out_data, 128'(8'hA5) << 40);

    // Back-pressure on channel 3, then drain-and-refill in one cycle
    out_ready = '0;
    in_sel = 4'd3; in_data = 8'h11; in_valid = 1'b1;
    cyc();
    in_data = 8'h22;
    cyc();
    check("bp3_stall", 128'(last_rdy), 128'(0));
    cyc();
    out_ready[3] = 1'b1;
    cyc();
    check("bp3_refill_valid", 128'(out_valid[3]), 128'(1));
    check("bp3_refill_data", 128'(out_data[31:24]), 128'(8'h22));
    in_valid = 1'b0;
    cyc();

    // Broadcast blocked by a stalled channel 7, then released
    out_ready = '0;
    in_sel = 4'd7; in_data = 8'h77; in_valid = 1'b1;
    cyc();
    in_bcast = 1'b1; in_data = 8'h5C;
    cyc();
    cyc();
    check("bc_blocked", 128'(out_valid), 128'(16'h0080));
    out_ready[7] = 1'b1;
    cyc();
    check("bc_all_valid", 128'(out_valid), 128'(16'hFFFF));
    check("bc_all_data", out_data, {16{8'h5C}});
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = '1;
    cyc();

    // Random traffic with random consumers
    for (int c = 0; c < 600; c++) begin
      if (!(in_valid && !last_rdy)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_bcast = ($urandom_range(0, 15) == 0);
        in_sel   = 4'($urandom_range(0, 15));
        in_data  = 8'($urandom);
      end
      out_ready = 16'($urandom) | 16'($urandom);
      cyc();
    end
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = '1;
    cyc();
    cyc();
    for (int k = 0; k < 16; k++) check($sformatf("sb_drained_ch%0d", k), 128'(sb[k].size()), 128'(0));

    // Asynchronous reset with channels 2 and 9 full
    out_ready = '0;
    in_sel = 4'd2; in_data = 8'hC2; in_valid = 1'b1;
    cyc();
    in_sel = 4'd9; in_data = 8'hC9;
    cyc();
    in_valid = 1'b0;
    check("pre_rst_valid", 128'(out_valid), 128'(16'h0204));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_valid", 128'(out_valid), 128'(0));
    check("async_rst_data", out_data, 128'(0));
    @(posedge clk);
    #1;
    check("rst_hold_valid", 128'(out_valid), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'(1));
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
